// File: rtl/iter_alu.sv
// iter_alu: multi-cycle execute unit on the consumer side of the ALUControl
// interface. Logic, arithmetic and compare ops finish in one cycle. Shifts
// move the operand one bit position per cycle, so the unit needs no barrel
// shifter.
//
// Handshakes (both sides): a transfer happens on a rising edge where valid
// and ready are both 1. Once valid is raised, the sender holds it and the
// payload stable until that edge. in_ready is high only in IDLE, so the unit
// holds at most one operation. out_valid is high only in DONE.
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   in_valid     SrcA/SrcB/ALUControl are valid
//   in_ready     unit can accept a new operation (state == IDLE)
//   SrcA         operand A (the value that is shifted)
//   SrcB         operand B; SrcB[SW-1:0] is the shift amount
//   ALUControl   4-bit operation code
//   out_valid    ALUResult holds a finished result (state == DONE)
//   out_ready    consumer takes the result
//   ALUResult    registered result
//   Zero         ALUResult == 0
//   dbg_state_o  current FSM state, for observation only
module iter_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [3:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic [1:0]       dbg_state_o
);

  localparam int SW = $clog2(WIDTH);

  // ALUControl encodings (the `ALU_* codes of define.v)
  localparam logic [3:0] ALU_NONE             = 4'd0;
  localparam logic [3:0] ALU_ADD              = 4'd1;
  localparam logic [3:0] ALU_SUB              = 4'd2;
  localparam logic [3:0] ALU_XOR              = 4'd3;
  localparam logic [3:0] ALU_OR               = 4'd4;
  localparam logic [3:0] ALU_AND              = 4'd5;
  localparam logic [3:0] ALU_SHIFTL           = 4'd6;
  localparam logic [3:0] ALU_SHIFTR           = 4'd7;
  localparam logic [3:0] ALU_SHIFTR_ARITH     = 4'd8;
  localparam logic [3:0] ALU_LESS_THAN        = 4'd9;
  localparam logic [3:0] ALU_LESS_THAN_SIGNED = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] res_q, res_d;

  logic [SW-1:0]    shamt;
  logic             is_shift;
  logic [WIDTH-1:0] single_res;
  logic [WIDTH-1:0] acc_shift;

  assign shamt    = SrcB[SW-1:0];
  assign is_shift = (ALUControl == ALU_SHIFTL) || (ALUControl == ALU_SHIFTR) ||
                    (ALUControl == ALU_SHIFTR_ARITH);

  // One-cycle ops, computed straight from the inputs sampled at accept
  always_comb begin
    single_res = '0;
    case (ALUControl)
      ALU_ADD:              single_res = SrcA + SrcB;
      ALU_SUB:              single_res = SrcA - SrcB;
      ALU_XOR:              single_res = SrcA ^ SrcB;
      ALU_OR:               single_res = SrcA | SrcB;
      ALU_AND:              single_res = SrcA & SrcB;
      ALU_LESS_THAN:        single_res = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
      ALU_LESS_THAN_SIGNED: single_res = {{(WIDTH-1){1'b0}},
                                          ($signed(SrcA) < $signed(SrcB))};
      // a shift by zero completes here and returns SrcA unchanged
      ALU_SHIFTL, ALU_SHIFTR, ALU_SHIFTR_ARITH: single_res = SrcA;
      default:              single_res = '0;
    endcase
  end

  // One bit position of the iterative shift, chosen by the latched op
  always_comb begin
    acc_shift = acc_q;
    case (op_q)
      ALU_SHIFTL:       acc_shift = {acc_q[WIDTH-2:0], 1'b0};
      ALU_SHIFTR:       acc_shift = {1'b0, acc_q[WIDTH-1:1]};
      ALU_SHIFTR_ARITH: acc_shift = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
      default:          acc_shift = acc_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (is_shift && (shamt != '0)) begin
            acc_d   = SrcA;
            cnt_d   = shamt;
            op_d    = ALUControl;
            state_d = S_SHIFT;
          end else begin
            res_d   = single_res;
            state_d = S_DONE;
          end
        end
      end
      S_SHIFT: begin
        acc_d = acc_shift;
        cnt_d = cnt_q - 1'b1;
        // cnt_q == 1 means this cycle applies the last bit position
        if (cnt_q == SW'(1)) begin
          res_d   = acc_shift;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      op_q    <= ALU_NONE;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      res_q   <= res_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign ALUResult   = res_q;
  assign Zero        = (res_q == '0);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_iter_alu.sv
module tb_iter_alu;

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_SLT  = 4'd10;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [3:0]  ALUControl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic        Zero;
  logic [1:0]  dbg_state;

  iter_alu #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .SrcA        (SrcA),
    .SrcB        (SrcB),
    .ALUControl  (ALUControl),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .ALUResult   (ALUResult),
    .Zero        (Zero),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int asserts   = 0;
  int failures  = 0;
  int n_results = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Results leave the DUT on a posedge with out_valid & out_ready; sample
  // just after the negedge so driver updates at that negedge are settled.
  always @(negedge clk) begin
    logic [31:0] e;
    #1;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        asserts++;
        failures++;
        $display("FAIL unexpected_result: got 0x%08h with no expected entry", ALUResult);
      end else begin
        e = exp_q.pop_front();
        check("result", ALUResult, e);
        check("zero", {31'd0, Zero}, {31'd0, (e == 32'd0)});
        n_results++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("wait_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  // Issue one op, push its expected result, measure latency to out_valid.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int exp_lat);
    int   lat;
    logic busy_ok;
    wait_ready();
    ALUControl = op;
    SrcA       = a;
    SrcB       = b;
    in_valid   = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    // scramble inputs: only the accept edge may matter
    SrcA       = $urandom;
    SrcB       = $urandom;
    ALUControl = 4'($urandom_range(0, 15));
    lat     = 1;
    busy_ok = 1'b1;
    while (!out_valid && lat < 200) begin
      if (in_ready) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, exp_lat);
    check("busy_not_ready", {31'd0, busy_ok}, 32'd1);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  int acc_cyc[4];
  int base_results;
  int n;
  logic [31:0] held;
  logic        hold_ok;
  logic        no_out;

  initial begin
    vecs[0]  = '{OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1};
    vecs[1]  = '{OP_SUB,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1};
    vecs[2]  = '{OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1};
    vecs[3]  = '{OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1};
    vecs[4]  = '{4'hF,    32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1};
    vecs[5]  = '{OP_NONE, 32'h0000_0012, 32'h0000_0034, 32'h0000_0000, 1};
    vecs[6]  = '{OP_OR,   32'hF000_000F, 32'h0F00_00F0, 32'hFF00_00FF, 1};
    vecs[7]  = '{OP_AND,  32'hF0F0_1234, 32'hFF00_FFFF, 32'hF000_1234, 1};
    vecs[8]  = '{OP_SLL,  32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 32};
    vecs[9]  = '{OP_SRA,  32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 5};
    vecs[10] = '{OP_SRL,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 5};
    vecs[11] = '{OP_SLL,  32'h0000_DEAD, 32'h0000_0020, 32'h0000_DEAD, 1};
    vecs[12] = '{OP_SRA,  32'hA5A5_A5A5, 32'hFFFF_FFE1, 32'hD2D2_D2D2, 2};
    vecs[13] = '{OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1};

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    SrcA       = '0;
    SrcB       = '0;
    ALUControl = OP_NONE;

    // reset state
    #3;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", ALUResult, 32'd0);
    check("rst_zero", {31'd0, Zero}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // table-driven vectors
    foreach (vecs[i]) do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // async reset in the middle of a long shift
    do_op(OP_ADD, 32'd3, 32'd4, 32'd7, 1);
    wait_ready();
    ALUControl = OP_SLL;
    SrcA       = 32'h0000_0001;
    SrcB       = 32'd20;
    in_valid   = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    check("midshift_state", {30'd0, dbg_state}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_result", ALUResult, 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    no_out = 1'b1;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) no_out = 1'b0;
    end
    check("abort_no_result", {31'd0, no_out}, 32'd1);

    // backpressure: result held, new inputs ignored
    out_ready = 1'b0;
    do_op(OP_XOR, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0, 1);
    hold_ok = 1'b1;
    held    = ALUResult;
    repeat (10) begin
      @(negedge clk);
      in_valid   = 1'b1;
      ALUControl = OP_ADD;
      SrcA       = $urandom;
      SrcB       = $urandom;
      #1;
      if (!out_valid || in_ready || ALUResult !== held) hold_ok = 1'b0;
    end
    check("bp_hold", {31'd0, hold_ok}, 32'd1);
    check("bp_value", held, 32'h0F0F_F0F0);
    @(negedge clk);
    ALUControl = OP_ADD;
    SrcA       = 32'd3;
    SrcB       = 32'd4;
    out_ready  = 1'b1;
    exp_q.push_back(32'd7);
    @(posedge clk);  // DONE -> IDLE
    @(posedge clk);  // new op accepted
    #1;
    in_valid = 1'b0;
    check("bp_next_accept", {31'd0, out_valid}, 32'd1);
    wait_ready();

    // back-to-back single-cycle ops with in_valid held high
    base_results = n_results;
    for (int i = 0; i < 4; i++) begin
      ALUControl = OP_ADD;
      SrcA       = 32'h100 * (i + 1);
      SrcB       = 32'(i);
      in_valid   = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      exp_q.push_back(32'h100 * (i + 1) + 32'(i));
      acc_cyc[i] = cyc;
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int i = 1; i < 4; i++) check("b2b_spacing", acc_cyc[i] - acc_cyc[i-1], 32'd2);
    repeat (4) @(negedge clk);
    check("b2b_count", n_results - base_results, 32'd4);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
